count_ctrl: RTL and testbench

Sequencing controller for a terminal-count counter datapath: a counter with a count enable, a synchronous clear and a carry-out level `co`. On `start` it clears the counter and runs it until carry-out, `PASSES` times in a row, then pulses `done`. A watchdog flags a counter that never reaches terminal count. Sits between the top-level control FSM and the counter instance it owns.

---
 rtl/count_ctrl.sv | 129 ++++++++++++
 tb/tb_count_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - pass sequencer for a terminal-count counter; COUNT_CTRL_TIMEOUT_EN builds the watchdog
module count_ctrl #(
    parameter int PASSES  = 4,
    parameter int PASS_W  = 3,
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clkEN,
    input  logic              co,
    output logic              cnt,
    output logic              cnt_clr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] pass_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef COUNT_CTRL_TIMEOUT_EN
    localparam logic [2:0] S_ERR   = 3'd4;
`endif

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES);

    logic [2:0]        state_q, state_d;
    logic [PASS_W-1:0] pass_q, pass_d;

`ifdef COUNT_CTRL_TIMEOUT_EN
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    // co in the same tick takes precedence over the watchdog
    assign timeout_hit = (state_q == S_RUN) && !co && clkEN &&
                         (timer_q == TMR_W'(TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT[0], TMR_W[0]};
`endif

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
`ifdef COUNT_CTRL_TIMEOUT_EN
        err_d   = err_q;
        timer_d = timer_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_CLEAR;
                    pass_d  = '0;
`ifdef COUNT_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
`ifdef COUNT_CTRL_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
`ifdef COUNT_CTRL_TIMEOUT_EN
                if (clkEN) begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
                if (stop) begin
                    state_d = S_IDLE;
                end else if (co) begin
                    pass_d  = pass_q + PASS_W'(1);
                    state_d = (pass_d == LAST_PASS) ? S_DONE : S_CLEAR;
                end
`ifdef COUNT_CTRL_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
`ifdef COUNT_CTRL_TIMEOUT_EN
            S_ERR:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
`ifdef COUNT_CTRL_TIMEOUT_EN
            err_q   <= 1'b0;
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
`ifdef COUNT_CTRL_TIMEOUT_EN
            err_q   <= err_d;
            timer_q <= timer_d;
`endif
        end
    end

    // cnt is the only Mealy output so the counter sees each prescaler tick directly
    assign cnt      = (state_q == S_RUN) && clkEN;
    assign cnt_clr  = (state_q == S_CLEAR);
    assign busy     = (state_q != S_IDLE);
    assign pass_cnt = pass_q;
`ifdef COUNT_CTRL_TIMEOUT_EN
    assign done     = (state_q == S_DONE) || (state_q == S_ERR);
    assign err      = err_q;
`else
    assign done     = (state_q == S_DONE);
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - scoreboard bench for count_ctrl driving a terminal-count counter model
module tb_count_ctrl;

    logic       clock = 1'b0;
    logic       reset, start, stop, clk_en, co;
    logic       cnt, cnt_clr, busy, done, err;
    logic [2:0] pass_cnt;

    count_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .clkEN(clk_en), .co(co), .cnt(cnt), .cnt_clr(cnt_clr),
        .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int base = 0;
    int term = 5;
    int count = 0;
    bit tri_mode = 1'b0;
    bit co_zero = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int pass;
        int err;
    } done_t;

    done_t done_q[$];
    int    clr_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (cnt_clr) count <= 0;
        else if (cnt) count <= (count == term) ? 0 : count + 1;
    end

    assign clk_en = tri_mode ? ((cyc - base) % 3 == 0) : 1'b1;
    assign co     = !co_zero && (count == term);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("cnt_and_clr", int'(cnt & cnt_clr), 0);
            chk("cnt_qualified", int'(cnt & ~(clk_en & busy)), 0);
            if (cnt_clr) begin
                chk("clr_expected", int'(clr_q.size() > 0), 1);
                if (clr_q.size() > 0) chk("clr_cycle", cyc - base, clr_q.pop_front());
            end
            if (done) begin
                chk("done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_cycle", cyc - base, e.cyc);
                    chk("done_pass_cnt", int'(pass_cnt), e.pass);
                    chk("done_err", int'(err), e.err);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic until_rel(input int r);
        while (cyc - base < r) tick(1);
    endtask

    task automatic launch();
        base  = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_four(input int plen);
        for (int i = 0; i < 4; i++) clr_q.push_back(1 + i * plen);
        done_q.push_back('{4 * plen + 1, 4, 0});
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cnt"}, int'(cnt), 0);
        chk({tag, "_cnt_clr"}, int'(cnt_clr), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_pass_cnt"}, int'(pass_cnt), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick(3);
        reset = 1'b0;
        chk_idle_outputs("reset");

        // four 7-cycle passes, then a back-to-back run one idle cycle later
        push_four(7);
        launch();
        until_rel(30);
        chk("held_busy", int'(busy), 0);
        chk("held_pass_cnt", int'(pass_cnt), 4);
        push_four(7);
        launch();
        until_rel(31);
        chk("b2b_pass_cnt", int'(pass_cnt), 4);

        // prescaler tick every third cycle
        tri_mode = 1'b1;
        clr_q.push_back(1); clr_q.push_back(17); clr_q.push_back(32); clr_q.push_back(47);
        done_q.push_back('{62, 4, 0});
        launch();
        until_rel(63);
        tri_mode = 1'b0;

`ifdef COUNT_CTRL_TIMEOUT_EN
        co_zero = 1'b1;
        clr_q.push_back(1);
        done_q.push_back('{66, 0, 1});
        launch();
        until_rel(67);
        chk("err_sticky", int'(err), 1);
        chk("err_pass_cnt", int'(pass_cnt), 0);
        co_zero = 1'b0;
        push_four(7);
        launch();
        chk("err_cleared", int'(err), 0);
        until_rel(30);
`else
        co_zero = 1'b1;
        clr_q.push_back(1);
        launch();
        until_rel(1000);
        chk("no_watchdog_busy", int'(busy), 1);
        chk("no_watchdog_err", int'(err), 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("no_watchdog_stopped", int'(busy), 0);
        co_zero = 1'b0;
`endif

        // co lands on the same tick the watchdog would trip
        term = 63;
        push_four(65);
        launch();
        until_rel(262);
        term = 5;

        // stop during pass 2, with an ignored start while busy
        clr_q.push_back(1); clr_q.push_back(8);
        launch();
        until_rel(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        until_rel(10);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_pass_cnt", int'(pass_cnt), 1);
        chk("stop_done", int'(done), 0);
        tick(3);
        chk("stop_clr_drained", clr_q.size(), 0);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", int'(busy), 0);
        tick(2);

        // reset mid-run, then a clean full run
        clr_q.push_back(1);
        launch();
        until_rel(5);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_idle_outputs("mid_reset");
        push_four(7);
        launch();
        until_rel(30);

        chk("clr_q_drained", clr_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
